// File: rtl/hangman_pkg.sv
// Shared constants and state type for the hangman guess-intake stage.
package hangman_pkg;

   localparam int WORD_LEN = 5;                      // letters per secret word
   localparam int ALPHA    = 26;                     // alphabet size / used-mask width
   localparam int CNT_W    = $clog2(WORD_LEN + 1);   // width of the letter counter
   localparam int WORD_W   = 8 * WORD_LEN;           // width of the packed secret word

   localparam logic [CNT_W-1:0] WORD_FULL = CNT_W'(WORD_LEN);

   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_Z  = 8'h5A;
   localparam logic [7:0] ASCII_LA = 8'h61;
   localparam logic [7:0] ASCII_LZ = 8'h7A;
   localparam logic [7:0] ASCII_BS = 8'h08;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] CASE_OFS = 8'h20;

   typedef enum logic [1:0] {SETUP, ARM, PLAY} intake_state_t;

endpackage

// File: rtl/ascii_letter_norm.sv
// Combinational letter classifier: folds lowercase to uppercase and gives the
// alphabet index (A=0) used to address the used-letter mask.
module ascii_letter_norm
   import hangman_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic       is_letter,
   output logic [7:0] upper,
   output logic [4:0] idx
);

   logic [7:0] ofs;

   // Classify and normalise; non-letters pass through with idx forced to 0.
   always_comb begin
      is_letter = 1'b0;
      upper     = in_byte;
      if (in_byte >= ASCII_LA && in_byte <= ASCII_LZ) begin
         is_letter = 1'b1;
         upper     = in_byte - CASE_OFS;
      end else if (in_byte >= ASCII_A && in_byte <= ASCII_Z) begin
         is_letter = 1'b1;
      end
      ofs = upper - ASCII_A;
      idx = is_letter ? ofs[4:0] : 5'd0;
   end

endmodule

// File: rtl/guess_intake.sv
// Guess intake: collects the secret word during SETUP, then filters player
// guesses (letters only, not busy, never repeated) during PLAY.
module guess_intake
   import hangman_pkg::*;
(
   input  logic              clk,
   input  logic              nRst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              game_rdy,
   input  logic              new_game,
   output logic [7:0]        guess,
   output logic [WORD_W-1:0] set_word,
   output logic              toggle_state,
   output logic [CNT_W-1:0]  word_count,
   output logic              in_play,
   output logic              dup_guess,
   output logic              bad_char
);

   intake_state_t    state;
   logic [ALPHA-1:0] used;
   logic             is_letter;
   logic [7:0]       letter;
   logic [4:0]       idx;

   ascii_letter_norm u_norm (
      .in_byte   (rx_data),
      .is_letter (is_letter),
      .upper     (letter),
      .idx       (idx)
   );

   // Single FSM block; every output is a register so pulses land one cycle
   // after the byte that caused them, and only one pulse can fire per cycle.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         state        <= SETUP;
         guess        <= '0;
         set_word     <= '0;
         word_count   <= '0;
         used         <= '0;
         toggle_state <= 1'b0;
         in_play      <= 1'b0;
         dup_guess    <= 1'b0;
         bad_char     <= 1'b0;
      end else begin
         toggle_state <= 1'b0;
         dup_guess    <= 1'b0;
         bad_char     <= 1'b0;
         if (new_game) begin
            // Abandon everything; a byte arriving alongside is silently dropped.
            state      <= SETUP;
            guess      <= '0;
            set_word   <= '0;
            word_count <= '0;
            used       <= '0;
            in_play    <= 1'b0;
         end else begin
            case (state)
               SETUP: begin
                  if (rx_valid) begin
                     if (is_letter) begin
                        if (word_count < WORD_FULL) begin
                           set_word   <= {set_word[WORD_W-9:0], letter};
                           word_count <= word_count + 1'b1;
                        end else begin
                           bad_char <= 1'b1;
                        end
                     end else if (rx_data == ASCII_BS) begin
                        if (word_count != '0) begin
                           set_word   <= set_word >> 8;
                           word_count <= word_count - 1'b1;
                        end else begin
                           bad_char <= 1'b1;
                        end
                     end else if (rx_data == ASCII_CR) begin
                        if (word_count == WORD_FULL) begin
                           // Pulse is raised together with entry to ARM so it
                           // is high for exactly the ARM cycle.
                           state        <= ARM;
                           toggle_state <= 1'b1;
                        end else begin
                           bad_char <= 1'b1;
                        end
                     end else begin
                        bad_char <= 1'b1;
                     end
                  end
               end
               ARM: begin
                  state   <= PLAY;
                  in_play <= 1'b1;
                  used    <= '0;
                  if (rx_valid) bad_char <= 1'b1;
               end
               PLAY: begin
                  if (rx_valid) begin
                     if (!is_letter || !game_rdy) begin
                        bad_char <= 1'b1;
                     end else if (used[idx]) begin
                        dup_guess <= 1'b1;
                     end else begin
                        // guess only ever moves to a fresh letter, so a
                        // downstream change detector sees one event per accept
                        guess     <= letter;
                        used[idx] <= 1'b1;
                     end
                  end
               end
               default: state <= SETUP;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_guess_intake.sv
// Directed self-checking bench for guess_intake.
module tb_guess_intake;

   logic        clk = 1'b0;
   logic        nRst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        game_rdy;
   logic        new_game;
   logic [7:0]  guess;
   logic [39:0] set_word;
   logic        toggle_state;
   logic [2:0]  word_count;
   logic        in_play;
   logic        dup_guess;
   logic        bad_char;

   int tests = 0;
   int fails = 0;

   guess_intake dut (
      .clk          (clk),
      .nRst         (nRst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .game_rdy     (game_rdy),
      .new_game     (new_game),
      .guess        (guess),
      .set_word     (set_word),
      .toggle_state (toggle_state),
      .word_count   (word_count),
      .in_play      (in_play),
      .dup_guess    (dup_guess),
      .bad_char     (bad_char)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one byte for one cycle, then sample 1 time unit after the edge.
   task automatic send(input logic [7:0] b, input logic rdy, input logic ng);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      game_rdy = rdy;
      new_game = ng;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      new_game = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      nRst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      nRst = 1'b1;
   endtask

   task automatic load_word_hello();
      send(8'h68, 1'b1, 1'b0);
      send(8'h65, 1'b1, 1'b0);
      send(8'h6C, 1'b1, 1'b0);
      send(8'h6C, 1'b1, 1'b0);
      send(8'h6F, 1'b1, 1'b0);
   endtask

   initial begin
      nRst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; game_rdy = 1'b1; new_game = 1'b0;
      do_reset();
      chk("rst_guess",   guess, 64'h0);
      chk("rst_word",    set_word, 64'h0);
      chk("rst_count",   word_count, 64'h0);
      chk("rst_pulses",  {toggle_state, dup_guess, bad_char, in_play}, 64'h0);

      // 1: partial word discarded by reset
      send(8'h41, 1'b1, 1'b0);
      send(8'h42, 1'b1, 1'b0);
      chk("t1_count_pre", word_count, 64'd2);
      chk("t1_word_pre",  set_word, 64'h4142);
      do_reset();
      chk("t1_count", word_count, 64'd0);
      chk("t1_word",  set_word, 64'h0);
      chk("t1_play",  in_play, 64'h0);

      // backspace on empty word rejected
      send(8'h08, 1'b1, 1'b0);
      chk("bs_empty_bad", bad_char, 64'h1);
      chk("bs_empty_cnt", word_count, 64'd0);

      // 2: lowercase word folded, CR arms, toggle for one cycle then PLAY
      load_word_hello();
      chk("t2_word",  set_word, 64'h48454C4C4F);
      chk("t2_count", word_count, 64'd5);
      send(8'h0D, 1'b1, 1'b0);
      chk("t2_toggle", toggle_state, 64'h1);
      chk("t2_noplay", in_play, 64'h0);
      idle();
      chk("t2_toggle_off", toggle_state, 64'h0);
      chk("t2_inplay",     in_play, 64'h1);

      // 3: backspace editing, short CR, overfull letter, byte during ARM
      do_reset();
      send(8'h48, 1'b1, 1'b0);
      send(8'h45, 1'b1, 1'b0);
      send(8'h4C, 1'b1, 1'b0);
      send(8'h08, 1'b1, 1'b0);
      chk("t3_bs_cnt",  word_count, 64'd2);
      chk("t3_bs_word", set_word, 64'h4845);
      send(8'h50, 1'b1, 1'b0);
      chk("t3_word", set_word[23:0], 64'h484550);
      chk("t3_cnt",  word_count, 64'd3);
      send(8'h0D, 1'b1, 1'b0);
      chk("t3_cr_bad",    bad_char, 64'h1);
      chk("t3_cr_notog",  toggle_state, 64'h0);
      idle();
      chk("t3_setup",     in_play, 64'h0);
      send(8'h4C, 1'b1, 1'b0);
      send(8'h4F, 1'b1, 1'b0);
      chk("t3_full_word", set_word, 64'h4845504C4F);
      send(8'h58, 1'b1, 1'b0);
      chk("t3_full_bad",  bad_char, 64'h1);
      chk("t3_full_word2", set_word, 64'h4845504C4F);
      chk("t3_full_cnt",  word_count, 64'd5);
      send(8'h0D, 1'b1, 1'b0);
      chk("t3_arm_tog", toggle_state, 64'h1);
      send(8'h41, 1'b1, 1'b0);
      chk("t3_arm_bad",  bad_char, 64'h1);
      chk("t3_arm_play", in_play, 64'h1);
      chk("t3_arm_guess", guess, 64'h0);

      // 4: accept then duplicate
      send(8'h65, 1'b1, 1'b0);
      chk("t4_guess", guess, 64'h45);
      chk("t4_flags", {dup_guess, bad_char}, 64'h0);
      send(8'h45, 1'b1, 1'b0);
      chk("t4_dup",       dup_guess, 64'h1);
      chk("t4_dup_guess", guess, 64'h45);
      chk("t4_dup_nobad", bad_char, 64'h0);

      // 5: non-letter, busy, then accepted
      send(8'h37, 1'b1, 1'b0);
      chk("t5_digit_bad", bad_char, 64'h1);
      send(8'h58, 1'b0, 1'b0);
      chk("t5_busy_bad",   bad_char, 64'h1);
      chk("t5_busy_guess", guess, 64'h45);
      send(8'h58, 1'b1, 1'b0);
      chk("t5_guess", guess, 64'h58);
      chk("t5_flags", {dup_guess, bad_char}, 64'h0);

      // 6: new_game swallows a same-cycle byte, then a fresh game reuses E
      send(8'h5A, 1'b1, 1'b1);
      chk("t6_play",   in_play, 64'h0);
      chk("t6_pulses", {toggle_state, dup_guess, bad_char}, 64'h0);
      chk("t6_guess",  guess, 64'h0);
      chk("t6_word",   set_word, 64'h0);
      chk("t6_cnt",    word_count, 64'd0);
      load_word_hello();
      send(8'h0D, 1'b1, 1'b0);
      chk("t6_toggle", toggle_state, 64'h1);
      idle();
      send(8'h45, 1'b1, 1'b0);
      chk("t6_guess_e", guess, 64'h45);
      chk("t6_nodup",   dup_guess, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
